vmask_expand: RTL and testbench
===============================

# vmask_expand

Mask expander for the vector ALU. It accepts a scalar element count N and a chunk count L. It then streams L mask chunks of REQ_DATA_WIDTH bits each, with the lowest N mask bits set to 1 and all remaining bits set to 0. This is the inverse of the mask population-count reduction: that block turns a mask stream into a scalar count, and this block turns a scalar count into a prefix ("thermometer") mask stream. Uses include building vl/tail masks and writing back count-derived masks, with one chunk address per beat.

## Interface
Parameters:
- REQ_DATA_WIDTH, 64, mask chunk width W in bits; must be a power of 2.
- RESP_DATA_WIDTH, 64, width of the count input and of the internal remaining-count register.
- REQ_ADDR_WIDTH, 32, chunk address and chunk-count width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; high only in IDLE and low while rst is high (combinational from state).
- in_count  in  RESP_DATA_WIDTH  number of leading mask bits to set (N).
- in_len  in  REQ_ADDR_WIDTH  number of chunks to emit (L).
- in_addr  in  REQ_ADDR_WIDTH  address of chunk 0.
- out_vec  out  REQ_DATA_WIDTH  current mask chunk; 0 whenever out_valid is low.
- out_addr  out  REQ_ADDR_WIDTH  chunk address; 0 whenever out_valid is low.
- out_valid  out  1  chunk valid.
- out_end  out  1  high together with out_valid on the last chunk of a request.
- out_ready  in  1  downstream accepts the presented chunk.

## Operation
- States: IDLE and EMIT.
- IDLE:
  - A request is accepted when in_valid & in_ready at a posedge.
  - On acceptance, latch rem = in_count, left = in_len and addr = in_addr.
  - If in_len == 0: stay in IDLE and emit nothing; the request is consumed.
  - Otherwise: go to EMIT and present chunk 0 on the next cycle.
- Chunk generation from the current rem:
  - If rem >= W: chunk = all ones, and next rem = rem - W.
  - Else: chunk = (1 << rem) - 1, computed with W-bit masking, never by a shift wider than W; next rem = 0.
  - Only the low log2(W)+1 bits of rem drive the partial-chunk decode.
- Per-beat fields:
  - out_addr = addr, and addr increments by 1 per chunk; wraps modulo 2^REQ_ADDR_WIDTH.
  - out_end = (left == 1).
- EMIT:
  - The registered outputs hold steady while out_valid & ~out_ready.
  - On out_valid & out_ready with left > 1: load the next chunk, addr + 1 and left - 1 into the output registers for the next cycle, with no bubble.
  - On the handshake of the out_end chunk: clear out_valid, out_end, out_vec and out_addr, and return to IDLE.
- Saturation: if N > L*W, every chunk is all ones. If N == 0, every chunk is all zeros. No error is flagged in either case.
- in_valid while not in_ready is ignored, and the inputs are not sampled.
- rst at any time, including mid-stream, aborts the request. State returns to IDLE, and the in-flight chunk is dropped without an out_end.

## Timing
- Reset values: out_vec = 0, out_addr = 0, out_valid = 0, out_end = 0, rem = 0, left = 0, state = IDLE. in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
- Latency: request accepted at edge T gives chunk 0 valid in cycle T+1.
- Throughput: one chunk per cycle with out_ready held high. An L-chunk request therefore occupies cycles T+1 .. T+L.
- Return to IDLE: after the last handshake at edge E, in_ready is high in the cycle after E. The earliest next acceptance is edge E+1, so there is a 1-cycle gap between requests.
- in_ready is low for the entire time the block is in EMIT. Request and response never overlap.
- Backpressure: out_ready low stalls indefinitely. All outputs and internal state stay stable while stalled.

## Test plan
W = 64 for all scenarios.
- Basic two-chunk request: N=100, L=2, addr=0x10, out_ready=1.
  - Cycle T+1: out_vec=0xFFFFFFFF_FFFFFFFF, addr 0x10, out_end=0.
  - Cycle T+2: out_vec=0x0000000F_FFFFFFFF, addr 0x11, out_end=1.
  - Cycle T+3: out_valid=0 and in_ready=1.
- Boundary counts:
  - N=64, L=1: a single all-ones chunk with out_end=1.
  - N=63, L=1: 0x7FFFFFFF_FFFFFFFF.
  - N=0, L=3: three zero chunks, addresses addr..addr+2, out_end on the third chunk.
- Saturation: N=500, L=2 gives two all-ones chunks.
- Zero length: L=0 gives no out_valid at all; in_ready returns high on the next cycle.
- Backpressure: N=130, L=3, with out_ready low for 4 cycles on chunk 1.
  - Chunk 1 (=all ones, addr+1) is held stable for the whole stall.
  - Chunk 2 = 0x3 with out_end=1.
  - Each chunk is emitted exactly once.
- Reset mid-stream: assert rst during chunk 1 of an L=4 request.
  - Next cycle: all outputs 0 and no out_end is seen.
  - A new request after reset is accepted normally, and its chunk 0 appears at T+1.

Source files
------------

// File: rtl/vmask_expand.sv
// Prefix (thermometer) mask expander: turns an element count N into a stream of
// L mask chunks of REQ_DATA_WIDTH bits with the lowest N bits set.
module vmask_expand #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [RESP_DATA_WIDTH-1:0] in_count,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_len,
    input  logic [REQ_ADDR_WIDTH-1:0]  in_addr,
    output logic [REQ_DATA_WIDTH-1:0]  out_vec,
    output logic [REQ_ADDR_WIDTH-1:0]  out_addr,
    output logic                       out_valid,
    output logic                       out_end,
    input  logic                       out_ready
);

    localparam int SHW = $clog2(REQ_DATA_WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                      state_q, state_d;
    logic [RESP_DATA_WIDTH-1:0]  rem_q, rem_d;
    logic [REQ_ADDR_WIDTH-1:0]   left_q, left_d;
    logic [REQ_DATA_WIDTH-1:0]   out_vec_q, out_vec_d;
    logic [REQ_ADDR_WIDTH-1:0]   out_addr_q, out_addr_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_end_q, out_end_d;

    logic [RESP_DATA_WIDTH-1:0]  chunk_src;
    logic [CW-1:0]               part_bits;
    logic [REQ_DATA_WIDTH-1:0]   chunk_vec;
    logic [RESP_DATA_WIDTH-1:0]  chunk_rem_next;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_vec   = out_vec_q;
    assign out_addr  = out_addr_q;
    assign out_valid = out_valid_q;
    assign out_end   = out_end_q;

    // Chunk 0 is built straight from in_count at acceptance; later chunks from rem_q.
    always_comb begin
        chunk_src = (state_q == IDLE) ? in_count : rem_q;
        part_bits = chunk_src[CW-1:0];
        if (chunk_src >= RESP_DATA_WIDTH'(REQ_DATA_WIDTH)) begin
            chunk_vec      = '1;
            chunk_rem_next = chunk_src - RESP_DATA_WIDTH'(REQ_DATA_WIDTH);
        end else begin
            chunk_vec      = ~({REQ_DATA_WIDTH{1'b1}} << part_bits[SHW-1:0]);
            chunk_rem_next = '0;
        end
    end

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        left_d      = left_q;
        out_vec_d   = out_vec_q;
        out_addr_d  = out_addr_q;
        out_valid_d = out_valid_q;
        out_end_d   = out_end_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    rem_d  = in_count;
                    left_d = in_len;
                    if (in_len != '0) begin
                        state_d     = EMIT;
                        rem_d       = chunk_rem_next;
                        out_vec_d   = chunk_vec;
                        out_addr_d  = in_addr;
                        out_valid_d = 1'b1;
                        out_end_d   = (in_len == REQ_ADDR_WIDTH'(1));
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (left_q > REQ_ADDR_WIDTH'(1)) begin
                        rem_d      = chunk_rem_next;
                        left_d     = left_q - REQ_ADDR_WIDTH'(1);
                        out_vec_d  = chunk_vec;
                        out_addr_d = out_addr_q + REQ_ADDR_WIDTH'(1);
                        out_end_d  = (left_q == REQ_ADDR_WIDTH'(2));
                    end else begin
                        state_d     = IDLE;
                        rem_d       = '0;
                        left_d      = '0;
                        out_vec_d   = '0;
                        out_addr_d  = '0;
                        out_valid_d = 1'b0;
                        out_end_d   = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            left_q      <= '0;
            out_vec_q   <= '0;
            out_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_end_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            left_q      <= left_d;
            out_vec_q   <= out_vec_d;
            out_addr_q  <= out_addr_d;
            out_valid_q <= out_valid_d;
            out_end_q   <= out_end_d;
        end
    end

endmodule

// File: tb/tb_vmask_expand.sv
// Self-checking bench for vmask_expand: bit-level prefix-mask model, scoreboard
// compare every cycle, plus hand-computed literal checks for the directed scenarios.
module tb_vmask_expand;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_count;
    logic [31:0] in_len;
    logic [31:0] in_addr;
    logic [63:0] out_vec;
    logic [31:0] out_addr;
    logic        out_valid;
    logic        out_end;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;

    typedef struct {
        logic [63:0] vec;
        logic [31:0] addr;
        logic        last;
    } beat_t;

    beat_t exp_q[$];

    vmask_expand #(
        .REQ_DATA_WIDTH (64),
        .RESP_DATA_WIDTH(64),
        .REQ_ADDR_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_count (in_count),
        .in_len   (in_len),
        .in_addr  (in_addr),
        .out_vec  (out_vec),
        .out_addr (out_addr),
        .out_valid(out_valid),
        .out_end  (out_end),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit j of chunk i is set exactly when its global bit position i*64+j is below N.
    function automatic logic [63:0] model_chunk(input logic [63:0] n, input int i);
        logic [63:0]  v;
        logic [127:0] pos;
        for (int j = 0; j < 64; j++) begin
            pos  = 128'(i) * 128'd64 + 128'(j);
            v[j] = ({64'b0, n} > pos);
        end
        return v;
    endfunction

    // Waits for in_ready, presents one request for a cycle and queues its expected beats.
    // Returns at 1 time unit after the acceptance edge (cycle T+1).
    task automatic send(input logic [63:0] n, input logic [31:0] l, input logic [31:0] a);
        int w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        for (int i = 0; i < int'(l); i++) begin
            beat_t b;
            b.vec  = model_chunk(n, i);
            b.addr = a + 32'(i);
            b.last = (i == int'(l) - 1);
            exp_q.push_back(b);
        end
        in_valid = 1'b1;
        in_count = n;
        in_len   = l;
        in_addr  = a;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_count = '0;
        in_len   = '0;
        in_addr  = '0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_idle_ready", {62'b0, out_valid, in_ready}, 64'd1);
    endtask

    // Scoreboard compare on the falling edge, away from the active edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("beat_vec", out_vec, exp_q[0].vec);
                    check("beat_addr", {32'b0, out_addr}, {32'b0, exp_q[0].addr});
                    check("beat_end", {63'b0, out_end}, {63'b0, exp_q[0].last});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end else begin
                check("idle_vec", out_vec, 64'd0);
                check("idle_addr_end", {31'b0, out_end, out_addr}, 64'd0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_count  = '0;
        in_len    = '0;
        in_addr   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_ready_low", {63'b0, in_ready}, 64'd0);
            check("rst_outputs", {out_vec[31:0] | 32'(out_vec[63:32]), out_addr} | 64'(out_valid) | 64'(out_end), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("ready_after_rst", {63'b0, in_ready}, 64'd1);

        // Basic two-chunk request
        send(64'd100, 32'd2, 32'h10);
        check("basic_c0_vec", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        check("basic_c0_addr", {32'b0, out_addr}, 64'h10);
        check("basic_c0_ve", {62'b0, out_valid, out_end}, 64'b10);
        @(posedge clk);
        #1;
        check("basic_c1_vec", out_vec, 64'h0000000F_FFFFFFFF);
        check("basic_c1_addr", {32'b0, out_addr}, 64'h11);
        check("basic_c1_ve", {62'b0, out_valid, out_end}, 64'b11);
        @(posedge clk);
        #1;
        check("basic_t3", {62'b0, out_valid, in_ready}, 64'b01);
        drain();

        // Boundary counts
        send(64'd64, 32'd1, 32'h20);
        check("n64_vec", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        check("n64_end", {63'b0, out_end}, 64'd1);
        drain();
        send(64'd63, 32'd1, 32'h21);
        check("n63_vec", out_vec, 64'h7FFFFFFF_FFFFFFFF);
        drain();
        send(64'd0, 32'd3, 32'hFFFF_FFFF);
        check("n0_c0_vec", out_vec, 64'd0);
        check("n0_c0_addr", {32'b0, out_addr}, 64'hFFFF_FFFF);
        @(posedge clk);
        #1;
        check("n0_c1_addr_wrap", {32'b0, out_addr}, 64'd0);
        drain();

        // Saturation
        send(64'd500, 32'd2, 32'h30);
        check("sat_c0", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        @(posedge clk);
        #1;
        check("sat_c1", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        check("sat_c1_end", {63'b0, out_end}, 64'd1);
        drain();

        // Zero length
        send(64'd5, 32'd0, 32'h38);
        check("len0_no_valid", {62'b0, out_valid, in_ready}, 64'b01);
        @(posedge clk);
        #1;
        check("len0_still_idle", {63'b0, out_valid}, 64'd0);

        // Backpressure on chunk 1
        hs0 = hs_cnt;
        send(64'd130, 32'd3, 32'h80);
        check("bp_c0", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_vec", out_vec, 64'hFFFFFFFF_FFFFFFFF);
            check("bp_hold_addr", {32'b0, out_addr}, 64'h81);
            check("bp_hold_ve", {61'b0, in_ready, out_valid, out_end}, 64'b010);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        check("bp_after_vec", out_vec, 64'hFFFFFFFF_FFFFFFFF);
        check("bp_after_addr", {32'b0, out_addr}, 64'h81);
        @(posedge clk);
        #1;
        check("bp_c2_vec", out_vec, 64'h3);
        check("bp_c2_end", {63'b0, out_end}, 64'd1);
        drain();
        check("bp_once_each", 64'(hs_cnt - hs0), 64'd3);

        // Reset mid-stream during chunk 1 of a 4-chunk request
        send(64'd300, 32'd4, 32'h40);
        @(posedge clk);
        #1;
        check("rs_c1_addr", {32'b0, out_addr}, 64'h41);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_vec", out_vec, 64'd0);
        check("rs_addr_end", {31'b0, out_end, out_addr}, 64'd0);
        check("rs_valid_ready", {62'b0, out_valid, in_ready}, 64'd0);
        exp_q.delete();
        rst = 1'b0;
        #1;
        check("rs_ready_back", {63'b0, in_ready}, 64'd1);
        send(64'd100, 32'd2, 32'h200);
        check("rs_new_lat", {63'b0, out_valid}, 64'd1);
        check("rs_new_addr", {32'b0, out_addr}, 64'h200);
        drain();

        // Additional model-checked vectors around chunk boundaries
        send(64'd65, 32'd2, 32'h5);
        drain();
        send(64'd127, 32'd2, 32'h6);
        drain();
        send(64'd128, 32'd3, 32'h7);
        drain();
        send(64'd1, 32'd1, 32'h8);
        check("n1_vec", out_vec, 64'h1);
        drain();
        send(64'hFFFFFFFF_FFFFFFFF, 32'd2, 32'h9);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
